// File: rtl/adxl362_seq_if.sv
// SPI byte-engine link and host register-access port of the ADXL362 sequencer.
// master = sequencer side, slave = byte engine / host side.
interface adxl362_seq_if;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic       spi_done;
    logic [7:0] spi_rx_byte;
    logic       n_CS;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;

    modport master (
        output spi_start, spi_tx_byte, n_CS, host_ack, host_rdata,
        input  spi_done, spi_rx_byte, host_req, host_we, host_addr, host_wdata
    );

    modport slave (
        input  spi_start, spi_tx_byte, n_CS, host_ack, host_rdata,
        output spi_done, spi_rx_byte, host_req, host_we, host_addr, host_wdata
    );
endinterface

// File: rtl/adxl362_seq.sv
// ADXL362 transaction sequencer: power-up config writes, periodic X/Y/Z burst reads
// and host single-register accesses multiplexed onto one SPI byte engine.
module adxl362_seq #(
    parameter int unsigned STARTUP_CYCLES = 250000,
    parameter int unsigned SOFTRST_WAIT   = 25000,
    parameter int unsigned SAMPLE_PERIOD  = 500000,
    parameter int unsigned CS_GAP         = 25,
    parameter logic [7:0]  FILTER_CFG     = 8'h13
) (
    input  logic          clk_50,
    input  logic          reset,
    adxl362_seq_if.master bus,
    output logic [11:0]   x_acc_reg,
    output logic [11:0]   y_acc_reg,
    output logic [11:0]   z_acc_reg,
    output logic          sample_valid,
    output logic          init_done,
    output logic          overrun
);

    localparam int unsigned WAIT_A   = (STARTUP_CYCLES > SOFTRST_WAIT) ? STARTUP_CYCLES : SOFTRST_WAIT;
    localparam int unsigned WAIT_MAX = (WAIT_A > CS_GAP) ? WAIT_A : CS_GAP;
    localparam int unsigned WW       = $clog2(WAIT_MAX + 1);
    localparam int unsigned TW       = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [7:0]  CMD_WR   = 8'h0A;
    localparam logic [7:0]  CMD_RD   = 8'h0B;

    typedef enum logic [2:0] {
        ST_STARTUP, ST_INIT, ST_SRWAIT, ST_IDLE, ST_ISSUE, ST_WAIT, ST_CSGAP
    } state_e;

    typedef enum logic [1:0] { TK_INIT, TK_HOST, TK_BURST } kind_e;

    state_e        state_q;
    kind_e         kind_q;
    logic [WW-1:0] wait_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    init_step_q;
    logic [3:0]    byte_q;
    logic [3:0]    last_q;
    logic [7:0]    cmd_q, addr_q, data_q;
    logic [7:0]    b2_q, yl_q, zl_q;
    logic [3:0]    xh_q, yh_q;
    logic          spi_start_q, ncs_q, host_ack_q;
    logic [7:0]    tx_q, host_rdata_q;
    logic [11:0]   x_q, y_q, z_q;
    logic          sample_valid_q, init_done_q, sample_due_q, overrun_q;
    logic          sample_fire_c, burst_go_c;

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [7:0] cmd,
                                              input logic [7:0] addr, input logic [7:0] data);
        case (idx)
            4'd0:    return cmd;
            4'd1:    return addr;
            4'd2:    return data;
            default: return 8'h00;
        endcase
    endfunction

    assign sample_fire_c = init_done_q && (timer_q == TW'(SAMPLE_PERIOD - 1));
    assign burst_go_c    = (state_q == ST_IDLE) && sample_due_q;

    // Sample timer: one pending trigger at most, a second one while pending flags overrun
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            timer_q      <= '0;
            sample_due_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (init_done_q) timer_q <= sample_fire_c ? '0 : timer_q + 1'b1;
            if (sample_fire_c) begin
                sample_due_q <= 1'b1;
                if (sample_due_q && !burst_go_c) overrun_q <= 1'b1;
            end else if (burst_go_c) begin
                sample_due_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_STARTUP;
            kind_q         <= TK_INIT;
            wait_q         <= WW'(STARTUP_CYCLES - 1);
            init_step_q    <= 2'd0;
            byte_q         <= 4'd0;
            last_q         <= 4'd0;
            cmd_q          <= 8'h00;
            addr_q         <= 8'h00;
            data_q         <= 8'h00;
            b2_q           <= 8'h00;
            yl_q           <= 8'h00;
            zl_q           <= 8'h00;
            xh_q           <= 4'h0;
            yh_q           <= 4'h0;
            spi_start_q    <= 1'b0;
            ncs_q          <= 1'b1;
            host_ack_q     <= 1'b0;
            tx_q           <= 8'h00;
            host_rdata_q   <= 8'h00;
            x_q            <= 12'h000;
            y_q            <= 12'h000;
            z_q            <= 12'h000;
            sample_valid_q <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            spi_start_q    <= 1'b0;
            host_ack_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            case (state_q)
                ST_STARTUP, ST_SRWAIT: begin
                    if (wait_q == '0) state_q <= ST_INIT;
                    else              wait_q  <= wait_q - 1'b1;
                end
                ST_INIT: begin
                    kind_q <= TK_INIT;
                    cmd_q  <= CMD_WR;
                    case (init_step_q)
                        2'd0:    begin addr_q <= 8'h1F; data_q <= 8'h52;       end
                        2'd1:    begin addr_q <= 8'h2C; data_q <= FILTER_CFG;  end
                        default: begin addr_q <= 8'h2D; data_q <= 8'h02;       end
                    endcase
                    last_q  <= 4'd2;
                    byte_q  <= 4'd0;
                    ncs_q   <= 1'b0;
                    state_q <= ST_ISSUE;
                end
                ST_IDLE: begin
                    // Pending sample beats the host; neither is looked at outside IDLE
                    if (sample_due_q) begin
                        kind_q  <= TK_BURST;
                        cmd_q   <= CMD_RD;
                        addr_q  <= 8'h0E;
                        data_q  <= 8'h00;
                        last_q  <= 4'd7;
                        byte_q  <= 4'd0;
                        ncs_q   <= 1'b0;
                        state_q <= ST_ISSUE;
                    end else if (bus.host_req && init_done_q) begin
                        kind_q  <= TK_HOST;
                        cmd_q   <= bus.host_we ? CMD_WR : CMD_RD;
                        addr_q  <= bus.host_addr;
                        data_q  <= bus.host_we ? bus.host_wdata : 8'h00;
                        last_q  <= 4'd2;
                        byte_q  <= 4'd0;
                        ncs_q   <= 1'b0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    spi_start_q <= 1'b1;
                    tx_q        <= frame_byte(byte_q, cmd_q, addr_q, data_q);
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.spi_done) begin
                        case (byte_q)
                            4'd2:    b2_q <= bus.spi_rx_byte;
                            4'd3:    xh_q <= bus.spi_rx_byte[3:0];
                            4'd4:    yl_q <= bus.spi_rx_byte;
                            4'd5:    yh_q <= bus.spi_rx_byte[3:0];
                            4'd6:    zl_q <= bus.spi_rx_byte;
                            default: ;
                        endcase
                        if (byte_q == last_q) begin
                            ncs_q   <= 1'b1;
                            wait_q  <= WW'(CS_GAP - 1);
                            state_q <= ST_CSGAP;
                            if (kind_q == TK_BURST) begin
                                x_q            <= {xh_q, b2_q};
                                y_q            <= {yh_q, yl_q};
                                z_q            <= {bus.spi_rx_byte[3:0], zl_q};
                                sample_valid_q <= 1'b1;
                            end
                            if (kind_q == TK_HOST && CS_GAP == 1) begin
                                host_ack_q <= 1'b1;
                                if (cmd_q == CMD_RD) host_rdata_q <= bus.spi_rx_byte;
                            end
                        end else begin
                            byte_q      <= byte_q + 4'd1;
                            spi_start_q <= 1'b1;
                            tx_q        <= frame_byte(byte_q + 4'd1, cmd_q, addr_q, data_q);
                        end
                    end
                end
                ST_CSGAP: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                        // Ack lands on the final gap cycle
                        if (wait_q == WW'(1) && kind_q == TK_HOST) begin
                            host_ack_q <= 1'b1;
                            if (cmd_q == CMD_RD) host_rdata_q <= b2_q;
                        end
                    end else if (!init_done_q) begin
                        case (init_step_q)
                            2'd0: begin
                                init_step_q <= 2'd1;
                                wait_q      <= WW'(SOFTRST_WAIT - 1);
                                state_q     <= ST_SRWAIT;
                            end
                            2'd1: begin
                                init_step_q <= 2'd2;
                                state_q     <= ST_INIT;
                            end
                            default: begin
                                init_done_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_STARTUP;
            endcase
        end
    end

    assign bus.spi_start   = spi_start_q;
    assign bus.spi_tx_byte = tx_q;
    assign bus.n_CS        = ncs_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.host_rdata  = host_rdata_q;
    assign x_acc_reg       = x_q;
    assign y_acc_reg       = y_q;
    assign z_acc_reg       = z_q;
    assign sample_valid    = sample_valid_q;
    assign init_done       = init_done_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_adxl362_seq.sv
// Directed bench for adxl362_seq with a byte-engine model answering 8 cycles after each start.
module tb_adxl362_seq;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [11:0] x_acc_reg, y_acc_reg, z_acc_reg;
    logic        sample_valid, init_done, overrun;

    adxl362_seq_if bus();

    adxl362_seq #(
        .STARTUP_CYCLES(16), .SOFTRST_WAIT(32), .SAMPLE_PERIOD(300), .CS_GAP(2), .FILTER_CFG(8'h13)
    ) dut (
        .clk_50(clk_50), .reset(reset), .bus(bus),
        .x_acc_reg(x_acc_reg), .y_acc_reg(y_acc_reg), .z_acc_reg(z_acc_reg),
        .sample_valid(sample_valid), .init_done(init_done), .overrun(overrun)
    );

    always #5 clk_50 = ~clk_50;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_q[$];
    int         hi_hist[$];
    logic [7:0] rx_tab [8];
    int         frames = 0;
    int         sv_count = 0;
    int         ack_count = 0;
    int         stall_extra = 0;
    bit         stall_req = 1'b0;
    bit         m_busy = 1'b0;
    int         m_cur = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_50);
        #1;
    endtask

    function automatic logic [95:0] pack_tx(input int from);
        logic [95:0] v = '0;
        for (int i = from; i < tx_q.size() && i < from + 12; i++) v = {v[87:0], tx_q[i]};
        return v;
    endfunction

    // Byte engine: done one cycle, rx byte picked by position within the CS frame
    initial begin
        int  m_cnt = 0;
        int  m_idx = 0;
        bit  stall_taken = 1'b0;
        bus.spi_done    = 1'b0;
        bus.spi_rx_byte = 8'h00;
        forever begin
            @(negedge clk_50 or negedge reset);
            if (!reset) begin
                bus.spi_done    = 1'b0;
                bus.spi_rx_byte = 8'h00;
                m_busy          = 1'b0;
                m_idx           = 0;
            end else begin
                bus.spi_done = 1'b0;
                if (bus.n_CS) m_idx = 0;
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.spi_done    = 1'b1;
                        bus.spi_rx_byte = rx_tab[m_cur[2:0]];
                        m_busy          = 1'b0;
                    end
                end else if (bus.spi_start) begin
                    m_cur = m_idx;
                    m_idx++;
                    tx_q.push_back(bus.spi_tx_byte);
                    m_busy = 1'b1;
                    m_cnt  = 8;
                    if (stall_req && !stall_taken && m_cur == 4) begin
                        m_cnt += stall_extra;
                        stall_taken = 1'b1;
                    end
                end
            end
        end
    end

    // Frame / pulse monitor
    initial begin
        int   hi_run = 0;
        logic prev_ncs = 1'b1;
        forever begin
            @(negedge clk_50);
            if (!reset) begin
                hi_run = 0;
            end else begin
                if (!bus.n_CS && prev_ncs) begin
                    frames++;
                    hi_hist.push_back(hi_run);
                end
                hi_run = bus.n_CS ? hi_run + 1 : 0;
                if (sample_valid) sv_count++;
                if (bus.host_ack) ack_count++;
            end
            prev_ncs = bus.n_CS;
        end
    end

    initial begin
        int n, tb, fb, hb, svb, ab;
        reset          = 1'b0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 8'h00;
        bus.host_wdata = 8'h00;
        for (int i = 0; i < 8; i++) rx_tab[i] = 8'h00;
        repeat (3) step();

        // reset state
        chk("rst_ncs", 96'(bus.n_CS), 96'd1);
        chk("rst_flags", 96'({bus.spi_start, bus.host_ack, sample_valid, init_done, overrun}), 96'd0);
        chk("rst_xyz", 96'({x_acc_reg, y_acc_reg, z_acc_reg, bus.host_rdata}), 96'd0);

        // 1: startup idle and the three init frames
        tb = tx_q.size(); fb = frames; hb = hi_hist.size();
        reset = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin step(); n++; end
        chk("t1_init_to", 96'(init_done), 96'd1);
        chk("t1_frames", 96'(frames - fb), 96'd3);
        chk("t1_tx_len", 96'(tx_q.size() - tb), 96'd9);
        chk("t1_tx", pack_tx(tb), 96'h0A1F520A2C130A2D02);
        chk("t1_startup_ge16", 96'(hi_hist[hb] >= 16), 96'd1);
        chk("t1_srwait_ge32", 96'(hi_hist[hb + 1] >= 32), 96'd1);

        // 2: burst read and axis assembly
        rx_tab[2] = 8'hF0; rx_tab[3] = 8'h0F; rx_tab[4] = 8'h34;
        rx_tab[5] = 8'h82; rx_tab[6] = 8'hFF; rx_tab[7] = 8'h07;
        tb = tx_q.size(); svb = sv_count;
        n = 0;
        while (sample_valid !== 1'b1 && n < 600) begin step(); n++; end
        chk("t2_sv_to", 96'(sample_valid), 96'd1);
        chk("t2_x", 96'(x_acc_reg), 96'h0FF0);
        chk("t2_y", 96'(y_acc_reg), 96'h0234);
        chk("t2_z", 96'(z_acc_reg), 96'h07FF);
        step();
        chk("t2_sv_pulse", 96'(sample_valid), 96'd0);
        chk("t2_sv_count", 96'(sv_count - svb), 96'd1);
        chk("t2_tx_len", 96'(tx_q.size() - tb), 96'd8);
        chk("t2_tx", pack_tx(tb), 96'h0B0E000000000000);

        // 3: host read of register 0x00
        rx_tab[2] = 8'hAD;
        tb = tx_q.size(); ab = ack_count;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h00; bus.host_wdata = 8'h77;
        n = 0;
        while (bus.host_ack !== 1'b1 && n < 200) begin step(); n++; end
        chk("t3_ack_to", 96'(bus.host_ack), 96'd1);
        chk("t3_rdata", 96'(bus.host_rdata), 96'hAD);
        bus.host_req = 1'b0;
        step();
        chk("t3_ack_pulse", 96'(bus.host_ack), 96'd0);
        chk("t3_ack_count", 96'(ack_count - ab), 96'd1);
        chk("t3_tx_len", 96'(tx_q.size() - tb), 96'd3);
        chk("t3_tx", pack_tx(tb), 96'h0B0000);

        // 4: host request in the cycle the sample trigger becomes pending
        tb = tx_q.size();
        n = 0;
        while (dut.sample_due_q !== 1'b1 && n < 400) begin step(); n++; end
        chk("t4_due_to", 96'(dut.sample_due_q), 96'd1);
        fb = frames; svb = sv_count;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h2C; bus.host_wdata = 8'h55;
        n = 0;
        while (bus.host_ack !== 1'b1 && n < 400) begin step(); n++; end
        chk("t4_ack_to", 96'(bus.host_ack), 96'd1);
        bus.host_req = 1'b0;
        chk("t4_frames", 96'(frames - fb), 96'd2);
        chk("t4_burst_first", 96'(sv_count - svb), 96'd1);
        chk("t4_tx_len", 96'(tx_q.size() - tb), 96'd11);
        chk("t4_tx", pack_tx(tb), 96'h0B0E0000000000000A2C55);
        chk("t4_gap_ge2", 96'(hi_hist[hi_hist.size() - 1] >= 2), 96'd1);
        chk("t4_rdata_held", 96'(bus.host_rdata), 96'hAD);
        chk("t4_no_overrun", 96'(overrun), 96'd0);

        // 5: stall a burst mid-frame across two trigger periods
        stall_extra = 600;
        stall_req   = 1'b1;
        n = 0;
        step();
        while (sample_valid !== 1'b1 && n < 1500) begin step(); n++; end
        chk("t5_sv_to", 96'(sample_valid), 96'd1);
        chk("t5_overrun", 96'(overrun), 96'd1);
        fb = frames; svb = sv_count;
        repeat (150) step();
        chk("t5_one_more_frame", 96'(frames - fb), 96'd1);
        chk("t5_one_more_sample", 96'(sv_count - svb), 96'd1);

        // 6: reset while the fifth burst byte is in flight
        n = 0;
        while (!(m_busy && m_cur == 4) && n < 500) begin step(); n++; end
        chk("t6_byte5_to", 96'(m_busy && m_cur == 4), 96'd1);
        step(); step();
        reset = 1'b0;
        #1;
        chk("t6_ncs", 96'(bus.n_CS), 96'd1);
        chk("t6_flags", 96'({bus.spi_start, bus.host_ack, sample_valid, init_done, overrun}), 96'd0);
        chk("t6_xyz", 96'({x_acc_reg, y_acc_reg, z_acc_reg, bus.host_rdata}), 96'd0);
        repeat (3) step();
        tb = tx_q.size(); fb = frames; hb = hi_hist.size();
        reset = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin step(); n++; end
        chk("t6_init_to", 96'(init_done), 96'd1);
        chk("t6_frames", 96'(frames - fb), 96'd3);
        chk("t6_tx_len", 96'(tx_q.size() - tb), 96'd9);
        chk("t6_tx", pack_tx(tb), 96'h0A1F520A2C130A2D02);
        chk("t6_startup_ge16", 96'(hi_hist[hb] >= 16), 96'd1);
        chk("t6_srwait_ge32", 96'(hi_hist[hb + 1] >= 32), 96'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
